// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DataSize      : default data/address width
//   dmem_state_e  : arbiter FSM state encoding
//   OwnerPipe/Dbg : owner IDs of the two requesters (port 0 / port 1)
package dmem_arbiter_pkg;

    localparam int unsigned DataSize = 32;

    typedef enum logic [1:0] {
        DmemIdle   = 2'd0,
        DmemAccess = 2'd1,
        DmemResp   = 2'd2
    } dmem_state_e;

    localparam logic OwnerPipe = 1'b0;  // pipeline MEM stage
    localparam logic OwnerDbg  = 1'b1;  // debug / DMA master

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
//   req0_* / rsp0_* : pipeline MEM-stage request and response
//   req1_* / rsp1_* : debug/DMA request and response
//   mem*            : single-port RAM strobes, address and data
//   pipeStall       : freeze toward the pipeline front end
// Modports: master = requesters + RAM side, slave = arbiter side.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DataSize
);
    logic              req0_valid;
    logic              req0_we;
    logic [DATA_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [DATA_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              memReadEnable;
    logic              memWriteEnable;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWriteData;
    logic [DATA_W-1:0] memReadData;

    logic              pipeStall;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output memReadData,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  memReadEnable, memWriteEnable, memAddr, memWriteData,
        input  pipeStall
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  memReadData,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output memReadEnable, memWriteEnable, memAddr, memWriteData,
        output pipeStall
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational two-way grant logic.
//   valid0, valid1 : qualified requests of port 0 / port 1
//   prefer1        : on a tie, grant port 1 (RR pointer or starvation flag)
//   grant          : one-hot grant, bit n = port n; 0 when nobody requests
module dmem_arb_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       prefer1,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = prefer1 ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the pipeline MEM stage (port 0) and a
// debug/DMA master (port 1). Each access runs IDLE -> ACCESS (MEM_LAT cycles)
// -> RESP (one-cycle response pulse).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requests, responses, RAM, pipeStall)
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority to port 0 with a starvation guard for port 1.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = DataSize,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned CntW = 4;

    dmem_state_e       state_q;
    logic              owner_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CntW-1:0]   cnt_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q;
    logic [DATA_W-1:0] rsp1_rdata_q;

    logic              arb_en;
    logic              prefer1;
    logic [1:0]        grant;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] capture;

    // No grant while reset is held, so every output is 0 during reset.
    assign arb_en = rst_n && (state_q == DmemIdle);

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr_q;

    assign prefer1 = rr_ptr_q;

    // Pointer moves to the port that was not granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (|grant) begin
            rr_ptr_q <= grant[0];
        end
    end
`else
    localparam int unsigned StW = $clog2(STARVE_MAX + 1);

    logic [StW-1:0] starve_q;

    assign prefer1 = (starve_q == StW'(STARVE_MAX));

    // Counts port-0 wins over a waiting port 1; cleared whenever port 1 wins
    // or is not requesting, so it never exceeds STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (|grant) begin
            if (grant[1] || !bus.req1_valid) begin
                starve_q <= '0;
            end else begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end
`endif

    dmem_arb_pick u_pick (
        .valid0  (arb_en & bus.req0_valid),
        .valid1  (arb_en & bus.req1_valid),
        .prefer1 (prefer1),
        .grant   (grant)
    );

    assign sel_we    = grant[1] ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;
    assign capture   = we_q ? '0 : bus.memReadData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DmemIdle;
            owner_q      <= OwnerPipe;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            unique case (state_q)
                DmemIdle: begin
                    if (|grant) begin
                        owner_q  <= grant[1] ? OwnerDbg : OwnerPipe;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        cnt_q    <= CntW'(MEM_LAT - 1);
                        mem_re_q <= !sel_we;
                        mem_we_q <= sel_we;
                        state_q  <= DmemAccess;
                    end
                end
                DmemAccess: begin
                    if (cnt_q == '0) begin
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (owner_q == OwnerDbg) begin
                            rsp1_rdata_q <= capture;
                            rsp1_valid_q <= 1'b1;
                        end else begin
                            rsp0_rdata_q <= capture;
                            rsp0_valid_q <= 1'b1;
                        end
                        state_q <= DmemResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DmemResp: begin
                    state_q <= DmemIdle;
                end
                default: begin
                    state_q <= DmemIdle;
                end
            endcase
        end
    end

    assign bus.req0_ready     = grant[0];
    assign bus.req1_ready     = grant[1];
    assign bus.rsp0_valid     = rsp0_valid_q;
    assign bus.rsp1_valid     = rsp1_valid_q;
    assign bus.rsp0_rdata     = rsp0_rdata_q;
    assign bus.rsp1_rdata     = rsp1_rdata_q;
    assign bus.memReadEnable  = mem_re_q;
    assign bus.memWriteEnable = mem_we_q;
    assign bus.memAddr        = addr_q;
    assign bus.memWriteData   = wdata_q;

    // Released during RESP so MEM_WB can capture the load data.
    assign bus.pipeStall = rst_n && (state_q != DmemResp) &&
                           ((bus.req0_valid && !bus.req0_ready) ||
                            (state_q == DmemAccess && owner_q == OwnerPipe));

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters:
  - port 0: pipeline MEM stage (load/store)
  - port 1: debug/DMA master
- Sequences each access through a fixed-latency memory window and returns registered read data.
- Raises a stall toward the pipeline while a port-0 request is pending or waiting.
- Sits between ALU_MEM and the data RAM; response feeds MEM_WB.

Parameters:
- DATA_W, 32, data and address width (matches `DataSize).
- MEM_LAT, 1, cycles the RAM needs per access (1..15).
- STARVE_MAX, 4, consecutive port-0 grants before port 1 is forced (fixed-priority mode only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  MEM-stage request.
- req0_we  in  1  1=store, 0=load.
- req0_addr  in  DATA_W  byte address.
- req0_wdata  in  DATA_W  store data.
- req0_ready  out  1  request accepted this cycle.
- rsp0_valid  out  1  one-cycle response pulse.
- rsp0_rdata  out  DATA_W  load data; 0 for stores.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- memReadEnable  out  1  RAM read strobe.
- memWriteEnable  out  1  RAM write strobe.
- memAddr  out  DATA_W  RAM address.
- memWriteData  out  DATA_W  RAM write data.
- memReadData  in  DATA_W  RAM read data, valid on the last latency cycle.
- pipeStall  out  1  freezes the pipeline front end.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - Latency counter, starvation counter and RR pointer are 0.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate among asserted req*_valid and assert req_ready for the winner in the same cycle (combinational).
  - Latch owner, we, addr and wdata.
  - Load counter with MEM_LAT-1 and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - memAddr and memWriteData are driven from the latched values.
  - memReadEnable = !we and memWriteEnable = we, held for every ACCESS cycle.
  - Counter decrements each cycle.
  - When counter = 0: capture memReadData (loads) or 0 (stores) into the owner's rsp_rdata, then go to RESP.
- RESP:
  - Assert owner's rsp_valid for exactly 1 cycle, then go to IDLE.
  - rsp_rdata holds its value until the next response on that port.
- Latency: accept cycle T; response pulse at T+MEM_LAT+1.
  - Minimum issue interval per port is MEM_LAT+2 cycles.
- Fixed priority:
  - Port 0 wins.
  - Starvation counter increments on each port-0 grant made while req1_valid=1.
  - When it reaches STARVE_MAX, the next simultaneous request goes to port 1 and the counter clears.
  - A port-1 grant, or req1_valid=0 at an arbitration point, also clears the counter.
- Request hold rule:
  - A requester holds valid, we, addr and wdata stable until req_ready.
  - Dropping valid before ready is legal; no access is made.
- pipeStall = req0_valid & !req0_ready, or owner=0 in ACCESS.
  - pipeStall is 0 during RESP so MEM_WB captures the data.
- Simultaneous arbitration: only one ready per cycle; the loser's ready stays 0.
- Reset mid-access aborts the access: no response, RAM strobes drop immediately.
- Address wrap and alignment are not checked; the address is passed through unchanged.

Optional Feature:
- DMEM_ARB_RR_EN
  - Defined: round-robin arbitration. The 1-bit pointer flips to the non-granted port after every grant. The starvation counter and STARVE_MAX are unused.
  - Undefined: fixed priority with starvation guard as above.

Decomposition:
- Shared package/define file (`define.v` style) holds:
  - State encodings (`DmemIdle=2'd0`, `DmemAccess=2'd1`, `DmemResp=2'd2`).
  - Owner IDs.
  - `DataSize` reuse.
- Natural sub-module: dmem_arb_pick.
  - Combinational grant logic: req0/req1 valid, RR pointer or starvation flag in; one-hot grant out.
  - Unit-testable alone.

Test Plan:
- Reset then single load: MEM_LAT=1; RAM[0x10]=0xDEADBEEF; req0 load 0x10 accepted cycle 1.
  - memReadEnable=1 in cycle 2.
  - rsp0_valid=1 and rsp0_rdata=0xDEADBEEF in cycle 3.
  - pipeStall=1 only in cycle 2.
- Store then load: req0 store 0x20 ← 0x12345678, then load 0x20.
  - memWriteEnable pulses once.
  - Second response rdata = 0x12345678; store response rdata = 0.
- Contention, fixed priority: both ports request continuously, STARVE_MAX=4.
  - Grant sequence 0,0,0,0,1,0,0,0,0,1.
  - Each port-1 response carries its own address's data.
- Round-robin (DMEM_ARB_RR_EN defined): both ports continuous.
  - Grants strictly alternate 0,1,0,1.
- MEM_LAT=3: a single load gets its response exactly 4 cycles after accept.
  - memReadEnable high for 3 consecutive cycles.
- rst_n low during ACCESS: all outputs 0 within the same cycle, no rsp_valid.
  - After release, a new req1 load completes normally.
